uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FPGA, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDIOS, default 9600, line baud rate.
REQ-003 SHALL have parameter DATA_WIDTH_UART, default 8, data bits per frame; legal range 5..32.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port data_rx, output, DATA_WIDTH_UART, last good received word.
REQ-008 SHALL have port rx_done, output, 1, one-cycle pulse when data_rx is updated.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-011 SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer, both flops reset to 1; all decisions use the synchronized value.
REQ-013 SHALL define BIT_CNT = CLK_FPGA/BAUDIOS (integer division) and HALF_CNT = BIT_CNT/2.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, each held in one state register.
REQ-015 IDLE: SHALL move to START on a synchronized high-to-low transition; a line held low SHALL NOT start a frame.
REQ-016 START: SHALL wait HALF_CNT cycles, then sample; low -> DATA with counter cleared; high -> IDLE, no error pulse (glitch reject).
REQ-017 DATA: SHALL sample every BIT_CNT cycles, shifting LSB-first into an internal shift register; after DATA_WIDTH_UART samples -> PARITY if enabled, else STOP.
REQ-018 PARITY: SHALL sample one bit after BIT_CNT cycles, record mismatch, then -> STOP.
REQ-019 STOP: SHALL sample after BIT_CNT cycles. High: data_rx <= shift register and rx_done = 1 for exactly one cycle. Low: frame_err = 1 for one cycle and data_rx is unchanged. Both cases -> IDLE.
REQ-020 rx_done/frame_err SHALL assert the cycle after the stop sample; rx_done and frame_err SHALL never be high together.
REQ-021 parity_err SHALL pulse in the same cycle as rx_done or frame_err when a mismatch was recorded; data_rx SHALL still update on a good stop bit.
REQ-022 Back-to-back frames SHALL be received with no lost frame when the next start edge arrives immediately after the stop bit.
REQ-023 data_rx SHALL hold its value between frames; there is no read handshake and a new frame overwrites it.

Reset
REQ-024 On rst_n low, the block SHALL go to IDLE with: data_rx = 0, rx_done = 0, busy = 0, frame_err = 0, parity_err = 0, counters = 0, synchronizer = 1.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL wait for a fresh falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: SHALL enable the PARITY state and check even parity (data bits XOR parity bit = 0).
REQ-027 Macro UART_RX_PARITY_EN undefined: PARITY state SHALL be skipped (DATA -> STOP) and parity_err SHALL be tied to 0.

Verification
REQ-028 Use CLK_FPGA=50000000, BAUDIOS=9600 (BIT_CNT=5208), no parity. Send 0xA5 -> data_rx=0xA5, a single rx_done pulse, busy high throughout the frame.
REQ-029 Stop bit forced low on 0x3C -> frame_err pulse, no rx_done, data_rx keeps its previous value.
REQ-030 rx low pulse of 1000 cycles while in IDLE -> return to IDLE, no pulses, data_rx unchanged.
REQ-031 Frames 0x01 and 0xFF sent back-to-back with zero idle -> two rx_done pulses, data_rx=0x01 then 0xFF.
REQ-032 rst_n asserted after 4 data bits, released, then 0x5A sent -> data_rx=0x5A, one rx_done.
REQ-033 With UART_RX_PARITY_EN and DATA_WIDTH_UART=20: send 0xABCDE with correct parity -> rx_done, no parity_err; send it with wrong parity -> rx_done and parity_err together.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, LSB-first, optional even parity (UART_RX_PARITY_EN)
module uart_rx #(
  parameter int CLK_FPGA        = 50000000,
  parameter int BAUDIOS         = 9600,
  parameter int DATA_WIDTH_UART = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx,
  output logic [DATA_WIDTH_UART-1:0] data_rx,
  output logic                       rx_done,
  output logic                       busy,
  output logic                       frame_err,
  output logic                       parity_err
);

  localparam int BIT_CNT  = CLK_FPGA / BAUDIOS;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT + 1);
  localparam int IW       = $clog2(DATA_WIDTH_UART + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH_UART - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                     state_q, state_d;
  // [0],[1] are the synchronizer, [2] is the previous synchronized value for edge detect
  logic [2:0]                 rx_pipe_q, rx_pipe_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [IW-1:0]              bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH_UART-1:0] shift_q, shift_d;
  logic [DATA_WIDTH_UART-1:0] data_rx_q, data_rx_d;
  logic                       rx_done_q, rx_done_d;
  logic                       frame_err_q, frame_err_d;
  logic                       rx_s, fall, tick, last_bit;
`ifdef UART_RX_PARITY_EN
  logic                       par_bad_q, par_bad_d;
  logic                       parity_err_q, parity_err_d;
`endif

  assign rx_s     = rx_pipe_q[1];
  assign fall     = rx_pipe_q[2] & ~rx_pipe_q[1];
  assign last_bit = (bit_idx_q == IDX_LAST);

  // State and datapath registers; the synchronizer resets to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_pipe_q    <= '1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_rx_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_pipe_q    <= rx_pipe_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_rx_q    <= data_rx_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Sample point: half a bit into the start bit, then one full bit period per later bit
  always_comb begin
    tick = 1'b0;
    case (state_q)
      S_START:                  tick = (cnt_q == HALF_LAST);
      S_DATA, S_PARITY, S_STOP: tick = (cnt_q == BIT_LAST);
      default:                  tick = 1'b0;
    endcase
  end

  // Next-state logic; a start bit that reads high at its midpoint is treated as a glitch
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (fall) state_d = S_START;
      S_START:  if (tick) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (tick && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bit timer, bit index, LSB-first shift register and parity tracking
  always_comb begin
    rx_pipe_d = {rx_pipe_q[1:0], rx};
    cnt_d     = (state_q == S_IDLE || tick) ? '0 : cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (state_q == S_START) bit_idx_d = '0;
    if (state_q == S_DATA && tick) begin
      shift_d   = {rx_s, shift_q[DATA_WIDTH_UART-1:1]};
      bit_idx_d = bit_idx_q + IW'(1);
    end
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    if (state_q == S_START) par_bad_d = 1'b0;
    if (state_q == S_PARITY && tick) par_bad_d = (^shift_q) ^ rx_s;
`endif
  end

  // Result pulses, registered so they appear the cycle after the stop sample
  always_comb begin
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    data_rx_d    = data_rx_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (state_q == S_STOP && tick) begin
      if (rx_s) begin
        rx_done_d = 1'b1;
        data_rx_d = shift_q;
      end else begin
        frame_err_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      parity_err_d = par_bad_q;
`endif
    end
  end

  assign data_rx   = data_rx_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
